fir_poly_serializer: RTL
========================

// Module: fir_poly_serializer
// PURPOSE
//   Output end of the 6-phase polyphase FIR used in the DWT filter bank.
//   Six phase modules produce y[6k+0..6k+5] in parallel, once per block.
//   This block accepts that 6-word block, rounds and saturates each word to
//   the stream width, and emits the words serially in time order.
//   The serial port is a valid/ready stream with backpressure.
//   A 2-bank ping-pong buffer lets one block be accepted while the previous one drains.
// PARAMETERS
//   y_out   20  width of each parallel phase input (signed)
//   w_out   16  width of serial output sample (signed)
//   shift    4  right-shift applied before saturation; 0 = no scaling or rounding
// PORTS
//   clk        in   1            single clock, rising edge
//   rstn       in   1            asynchronous active-low reset
//   y_6k_0..5  in   y_out each   signed phase outputs, y_6k_0 is earliest in time
//   in_valid   in   1            the six y_6k_* words form a valid block this cycle
//   in_ready   out  1            a free bank is available; block accepted on in_valid&in_ready
//   out_data   out  w_out        signed rounded/saturated sample
//   out_valid  out  1            out_data holds a valid sample
//   out_ready  in   1            sink accepts the sample on out_valid&out_ready
//   out_phase  out  3            index 0..5 of the current sample within its block
//   out_last   out  1            high with out_valid when out_phase==5
//   sat_flag   out  1            sticky; set when any accepted word saturated
// BEHAVIOUR
//   - Reset (async, rstn=0): both banks empty, wr_bank=rd_bank=0, idx=0.
//     Reset outputs: in_ready=1, out_valid=0, out_last=0, out_phase=0,
//     out_data=0, sat_flag=0. Bank contents are don't-care.
//   - Register-only outputs: in_ready, out_valid, out_phase, out_last and
//     out_data are functions of registers only; no combinational path from
//     in_valid or out_ready.
//   - Occupancy: full_cnt in {0,1,2}.
//     in_ready = (full_cnt!=2). out_valid = (full_cnt!=0).
//   - Accept (in_valid&in_ready): round/sat all six words, store them in bank
//     wr_bank, toggle wr_bank. The next cycle out_valid=1 if it was empty.
//     First-sample latency is 1 clk.
//   - Drain: out_data = bank[rd_bank][idx]. On out_valid&out_ready, idx
//     increments. When idx==5, idx wraps to 0, rd_bank toggles and full_cnt
//     decrements.
//   - No handshake (out_valid&!out_ready): out_data, out_phase and out_last
//     hold stable.
//   - Simultaneous accept and final-word pop: full_cnt is unchanged. Allowed
//     at full_cnt==1 only, since in_ready=0 at full_cnt==2.
//   - Full (full_cnt==2): in_ready=0 and in_valid is ignored, so no data is
//     lost or overwritten. The upstream must hold its block.
//   - Throughput: sustained rate 1 sample/clk with no bubble between blocks
//     while out_ready=1.
//   - Rounding: r = (y + (shift>0 ? 2^(shift-1) : 0)) >>> shift, computed at
//     y_out+1 bits so it cannot overflow.
//   - Saturation: r > 2^(w_out-1)-1 gives the max; r < -2^(w_out-1) gives the
//     min. Either case sets sat_flag, which clears only on reset.
//   - Reset mid-block: the partial block is discarded. No out_valid until a
//     new accept.
// STRUCTURE
//   - Shared package fir_pkg:
//       N_PHASE=6, PHASE_W=3, localparams for the bank count (2) and the
//       occupancy width (2).
//   - Sub-module fir_round_sat (combinational, params y_out/w_out/shift;
//     ports din, dout, sat). Six instances sit on the write side.
//   - Top level: 2x6 x w_out storage, wr_bank/rd_bank/idx/full_cnt registers
//     and the sat_flag register.
// TESTING
//   1. Reset with in_valid=1 held: in_ready=1, out_valid=0, out_data=0.
//      No accept occurs until rstn rises.
//   2. shift=4, block 16,32,...,96 with out_ready=1: out_data 1,2,3,4,5,6 on
//      6 consecutive clks; out_phase 0..5; out_last only on 6.
//      First out_valid 1 clk after accept.
//   3. Words 24 and -24, shift=4: out_data 2 and -1.
//      These are the round-half-up cases (1.5 -> 2, -1.5 -> -1).
//   4. Words 2^(y_out-1)-1 and -2^(y_out-1): out_data 32767 and -32768;
//      sat_flag goes to 1 and stays 1.
//   5. out_ready=0: accept 3 blocks back-to-back. Blocks 1 and 2 are
//      accepted; in_ready=0 afterwards; block 3 is held.
//      Release out_ready: all 12 samples emerge in order with no gaps.
//      Block 3 is accepted the cycle after the last pop of block 1 makes
//      in_ready=1.
//   6. Random out_ready stalls and in_valid gaps against a scoreboard model:
//      no loss, duplication or reordering; data stable while stalled.
//      Also assert rstn mid-block: the stream restarts clean.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the polyphase FIR output serializer.
package fir_pkg;

    localparam int N_PHASE = 6;
    localparam int PHASE_W = 3;
    localparam int N_BANK  = 2;
    localparam int OCC_W   = 2;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [OCC_W-1:0]   occ_t;

    localparam phase_t LAST_PHASE = phase_t'(N_PHASE - 1);

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up by an arithmetic right shift, then saturate to the stream width.
module fir_round_sat #(
    parameter int y_out = 20,
    parameter int w_out = 16,
    parameter int shift = 4
) (
    input  logic signed [y_out-1:0] din,
    output logic signed [w_out-1:0] dout,
    output logic                    sat
);

    localparam int     RND_SH = (shift > 0) ? shift - 1 : 0;
    localparam longint MAX_L  = (longint'(1) << (w_out - 1)) - 1;
    localparam longint MIN_L  = -MAX_L - 1;
    localparam logic signed [y_out:0] MAX_V = (y_out + 1)'(MAX_L);
    localparam logic signed [y_out:0] MIN_V = (y_out + 1)'(MIN_L);

    logic signed [y_out:0] rnd;
    logic signed [y_out:0] sum;
    logic signed [y_out:0] r;
    logic                  over;
    logic                  under;

    // One guard bit keeps the rounding add from overflowing at full scale.
    always_comb begin
        rnd = '0;
        if (shift > 0) rnd[RND_SH] = 1'b1;
        sum   = {din[y_out-1], din} + rnd;
        r     = sum >>> shift;
        over  = (r > MAX_V);
        under = (r < MIN_V);
        sat   = over | under;
        dout  = r[w_out-1:0];
        if (over)  dout = MAX_V[w_out-1:0];
        if (under) dout = MIN_V[w_out-1:0];
    end

endmodule

// File: rtl/fir_poly_serializer.sv
// Accepts a 6-word polyphase block, rounds/saturates it into a ping-pong bank
// and streams the words out one per handshake in time order.
module fir_poly_serializer
    import fir_pkg::*;
#(
    parameter int y_out = 20,
    parameter int w_out = 16,
    parameter int shift = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [y_out-1:0] y_6k_0,
    input  logic signed [y_out-1:0] y_6k_1,
    input  logic signed [y_out-1:0] y_6k_2,
    input  logic signed [y_out-1:0] y_6k_3,
    input  logic signed [y_out-1:0] y_6k_4,
    input  logic signed [y_out-1:0] y_6k_5,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [w_out-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PHASE_W-1:0]      out_phase,
    output logic                    out_last,
    output logic                    sat_flag
);

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; a producer holding valid keeps its data
    // stable until then. in_ready/out_valid depend on registers only.

    logic signed [y_out-1:0] y_in    [N_PHASE];
    logic signed [w_out-1:0] rs_data [N_PHASE];
    logic [N_PHASE-1:0]      rs_sat;
    logic [w_out-1:0]        mem     [N_BANK][N_PHASE];

    occ_t   full_cnt;
    logic   wr_bank;
    logic   rd_bank;
    phase_t idx;

    logic accept;
    logic pop;
    logic pop_last;

    assign y_in[0] = y_6k_0;
    assign y_in[1] = y_6k_1;
    assign y_in[2] = y_6k_2;
    assign y_in[3] = y_6k_3;
    assign y_in[4] = y_6k_4;
    assign y_in[5] = y_6k_5;

    for (genvar p = 0; p < N_PHASE; p++) begin : g_rs
        fir_round_sat #(
            .y_out(y_out),
            .w_out(w_out),
            .shift(shift)
        ) u_rs (
            .din (y_in[p]),
            .dout(rs_data[p]),
            .sat (rs_sat[p])
        );
    end

    assign in_ready  = (full_cnt != occ_t'(N_BANK));
    assign out_valid = (full_cnt != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign pop_last  = pop & (idx == LAST_PHASE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_cnt <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            idx      <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (accept) wr_bank <= ~wr_bank;
            if (pop) begin
                if (pop_last) begin
                    idx     <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    idx <= idx + phase_t'(1);
                end
            end
            // Accept into one bank while the other releases: occupancy holds.
            if (accept && !pop_last)      full_cnt <= full_cnt + occ_t'(1);
            else if (!accept && pop_last) full_cnt <= full_cnt - occ_t'(1);
            if (accept && (|rs_sat)) sat_flag <= 1'b1;
        end
    end

    // Bank contents need no reset; out_data is masked until a block lands.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int p = 0; p < N_PHASE; p++) mem[wr_bank][p] <= rs_data[p];
        end
    end

    assign out_phase = idx;
    assign out_last  = out_valid & (idx == LAST_PHASE);
    assign out_data  = out_valid ? mem[rd_bank][idx] : '0;

endmodule
